// File: rtl/ctx_regfile_mover_pkg.sv
// ctx_regfile_mover_pkg: shared state encoding and address helper for the context mover
package ctx_regfile_mover_pkg;

    localparam int REG_IDX_W  = 5;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,
        SAVE_RD,
        SAVE_WR,
        RST_RD,
        RST_WR,
        FINISH
    } state_e;

    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [REG_IDX_W-1:0] idx);
        return base + 32'(idx) * 32'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/ctx_regfile_mover.sv
// ctx_regfile_mover: walks registers FIRST_REG..NUM_REGS-1 between the register file and data memory
module ctx_regfile_mover
    import ctx_regfile_mover_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int FIRST_REG  = 1,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  SAVE,
    input  logic                  RESTORE,
    input  logic [31:0]           BASE_ADDR,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [REG_IDX_W-1:0]  RF_ADDR,
    input  logic [DATA_WIDTH-1:0] RF_RDATA,
    output logic [DATA_WIDTH-1:0] RF_WDATA,
    output logic                  RF_WRITE,
    output logic [31:0]           MEM_ADDRESS,
    output logic                  MEM_WRITE,
    output logic                  MEM_READ,
    output logic [DATA_WIDTH-1:0] MEM_WRITEDATA,
    input  logic [DATA_WIDTH-1:0] MEM_READDATA,
    input  logic                  MEM_BUSYWAIT
);

    localparam logic [REG_IDX_W-1:0] FIRST = REG_IDX_W'(FIRST_REG);
    localparam logic [REG_IDX_W-1:0] LAST  = REG_IDX_W'(NUM_REGS - 1);

    state_e                  state_q, state_d;
    logic [REG_IDX_W-1:0]    idx_q, idx_d;
    logic [31:0]             base_q, base_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [REG_IDX_W-1:0]    rf_addr_q, rf_addr_d;
    logic [DATA_WIDTH-1:0]   rf_wdata_q, rf_wdata_d;
    logic                    rf_write_q, rf_write_d;
    logic [31:0]             mem_addr_q, mem_addr_d;
    logic                    mem_write_q, mem_write_d;
    logic                    mem_read_q, mem_read_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (SAVE || RESTORE) begin
                    state_d = SAVE ? SAVE_RD : RST_RD;
                    base_d  = BASE_ADDR & ~32'h3;
                    idx_d   = FIRST;
                end
            end
            SAVE_RD: begin
                data_d  = RF_RDATA;
                state_d = SAVE_WR;
            end
            SAVE_WR: begin
                if (!MEM_BUSYWAIT) begin
                    state_d = (idx_q == LAST) ? FINISH : SAVE_RD;
                    idx_d   = (idx_q == LAST) ? idx_q : idx_q + 1'b1;
                end
            end
            RST_RD: begin
                if (!MEM_BUSYWAIT) begin
                    data_d  = MEM_READDATA;
                    state_d = RST_WR;
                end
            end
            RST_WR: begin
                state_d = (idx_q == LAST) ? FINISH : RST_RD;
                idx_d   = (idx_q == LAST) ? idx_q : idx_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // Outputs are decoded from the next state so they are registered yet aligned with it
        busy_d      = state_d != IDLE;
        done_d      = state_d == FINISH;
        mem_write_d = state_d == SAVE_WR;
        mem_read_d  = state_d == RST_RD;
        rf_write_d  = state_d == RST_WR;
        rf_addr_d   = (state_d == SAVE_RD || state_d == RST_WR) ? idx_d : '0;
        rf_wdata_d  = rf_write_d ? data_d : '0;
        mem_addr_d  = (mem_write_d || mem_read_d) ? word_addr(base_d, idx_d) : '0;
        mem_wdata_d = mem_write_d ? data_d : '0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            idx_q       <= FIRST;
            base_q      <= '0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rf_addr_q   <= '0;
            rf_wdata_q  <= '0;
            rf_write_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            base_q      <= base_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rf_addr_q   <= rf_addr_d;
            rf_wdata_q  <= rf_wdata_d;
            rf_write_q  <= rf_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_write_q <= mem_write_d;
            mem_read_q  <= mem_read_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign BUSY          = busy_q;
    assign DONE          = done_q;
    assign RF_ADDR       = rf_addr_q;
    assign RF_WDATA      = rf_wdata_q;
    assign RF_WRITE      = rf_write_q;
    assign MEM_ADDRESS   = mem_addr_q;
    assign MEM_WRITE     = mem_write_q;
    assign MEM_READ      = mem_read_q;
    assign MEM_WRITEDATA = mem_wdata_q;

endmodule

// File: doc/ctx_regfile_mover.md
Name: ctx_regfile_mover

Overview:
- Context save/restore sequencer for OS context switches.
- On SAVE, it walks the 32-bit register file, reading registers FIRST_REG..NUM_REGS-1 and writing each to data memory at a base address.
- On RESTORE, it reads those words back from memory and writes them into the register file.
- It sits beside the CPU core and drives the register file's read/write ports and the data-memory port while the core is stalled.

Parameters:
- NUM_REGS, 32, number of architectural registers; index width is 5 bits.
- FIRST_REG, 1, first register transferred; x0 is never saved or restored.
- DATA_WIDTH, 32, register and memory word width.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- SAVE  in  1  start save; sampled only in IDLE.
- RESTORE  in  1  start restore; sampled only in IDLE.
- BASE_ADDR  in  32  memory base address; captured at command accept with bits [1:0] forced to 0.
- BUSY  out  1  high in every non-IDLE state.
- DONE  out  1  one-cycle pulse at the end of an operation.
- RF_ADDR  out  5  register file read/write address.
- RF_RDATA  in  32  register file read data, combinational from RF_ADDR.
- RF_WDATA  out  32  register file write data.
- RF_WRITE  out  1  register file write enable; write occurs on the CLK edge.
- MEM_ADDRESS  out  32  memory word address.
- MEM_WRITE  out  1  memory write request.
- MEM_READ  out  1  memory read request.
- MEM_WRITEDATA  out  32  memory write data.
- MEM_READDATA  in  32  memory read data; valid when MEM_BUSYWAIT is low during a read.
- MEM_BUSYWAIT  in  1  memory stall.

Behaviour:
- Reset values: all outputs 0; state IDLE; index = FIRST_REG; data latch = 0.
- RESET mid-operation aborts immediately to IDLE. Partial memory or register-file contents are not rolled back, and DONE is not pulsed.
- States: IDLE, SAVE_RD, SAVE_WR, RST_RD, RST_WR, FINISH.
- IDLE:
  - SAVE=1 → SAVE_RD.
  - Else RESTORE=1 → RST_RD.
  - SAVE has priority when both are high.
  - On accept: capture BASE_ADDR, set index = FIRST_REG.
- SAVE_RD: RF_ADDR=index. RF_RDATA is latched into the data register at the edge → SAVE_WR.
- SAVE_WR:
  - Drive MEM_WRITE=1, MEM_ADDRESS = base + 4*index, MEM_WRITEDATA = latch.
  - All three are held stable while MEM_BUSYWAIT=1.
  - The transfer completes on the first edge with MEM_BUSYWAIT=0.
  - On completion: if index = NUM_REGS-1 → FINISH, else index+1 → SAVE_RD.
- RST_RD:
  - Drive MEM_READ=1, MEM_ADDRESS = base + 4*index; held while MEM_BUSYWAIT=1.
  - On the first edge with MEM_BUSYWAIT=0, latch MEM_READDATA → RST_WR.
- RST_WR:
  - RF_WRITE=1, RF_ADDR=index, RF_WDATA=latch for exactly one cycle.
  - Then if index = NUM_REGS-1 → FINISH, else index+1 → RST_RD.
- FINISH: DONE=1 for one cycle, BUSY=1 → IDLE.
- MEM_READ, MEM_WRITE and RF_WRITE are never high simultaneously. All are 0 in IDLE and FINISH.
- Address arithmetic is 32-bit, modulo 2^32; wrap past 0xFFFFFFFC is permitted and not flagged.
- Latency with MEM_BUSYWAIT always 0: 31 registers × 2 cycles + 1 FINISH. DONE is asserted 63 cycles after the accept edge, for both SAVE and RESTORE.
- Each cycle of MEM_BUSYWAIT=1 adds exactly one cycle.
- SAVE/RESTORE asserted while BUSY: ignored, not queued.
- A command held high through FINISH is re-accepted in the IDLE cycle that follows.

Decomposition:
- Shared package: state encoding constants (IDLE..FINISH), REG_IDX_W=5, WORD_BYTES=4.
- No sub-module required. An optional address generator (ctx_addr_gen: base + index<<2) may be factored out if reused by the cache-context mover.

Test Plan:
- Save, zero wait: preload reg[i]=0xA5000000+i, BASE_ADDR=0x1000, SAVE pulse → mem[0x1004..0x107C] = reg[1..31], mem[0x1000] untouched, DONE at accept+63, BUSY high 63 cycles.
- Restore, zero wait: mem[0x2000+4i]=0x5A000000+i, RESTORE → reg[i]=0x5A000000+i for i=1..31, reg[0] unchanged, DONE at accept+63.
- Memory stalls: BUSYWAIT=1 for 3 cycles on every access during SAVE → MEM_ADDRESS/MEM_WRITEDATA stable across stalls, DONE at accept+63+93.
- Simultaneous SAVE=RESTORE=1 with BASE_ADDR=0x3003 → save performed at base 0x3000; commands mid-operation ignored (exactly one DONE).
- RESET asserted during RST_WR of register 10 → next cycle all outputs 0, BUSY=0, no DONE; registers 1..9 restored, 11..31 unchanged.
- Round trip: SAVE to 0x4000, corrupt all registers, RESTORE from 0x4000 → register file identical to the original.
